// File: rtl/decoder_onehot_sequencer.sv
// rtl/decoder_onehot_sequencer.sv - registered N-to-2^N one-hot decoder with timed hold and scan mode
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ena        block enable; low forces IDLE and clears outputs
//   mode       0 = DECODE (handshake-driven), 1 = SCAN (autonomous walk)
//   in_valid   index valid (DECODE)
//   in_ready   block can accept an index this cycle (combinational)
//   in         index to decode
//   dwell      hold length minus one, in cycles, per one-hot position
//   out        registered one-hot (or all-zero) select
//   out_valid  registered, equals |out
//   scan_wrap  one-cycle pulse on the first cycle of out[0] after out[OUTS-1]

module decoder_onehot_sequencer #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [(2**N)-1:0]    out,
    output logic                 out_valid,
    output logic                 scan_wrap
);

    localparam int OUTS = 2**N;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [OUTS-1:0]     out_q, out_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic                valid_q;
    logic [OUTS-1:0]     onehot_in;
    logic                accept;

    // A new index is taken from IDLE, or on the final cycle of a hold so that
    // back-to-back decodes run without a zero gap.
    assign in_ready  = ena & ~mode & ((state_q == IDLE) |
                                      ((state_q == HOLD) & (cnt_q == '0)));
    assign accept    = in_valid & in_ready;
    assign onehot_in = {{(OUTS-1){1'b0}}, 1'b1} << in;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (!ena) begin
            state_d = IDLE;
            out_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_d = '0;
                    if (accept) begin
                        state_d = HOLD;
                        out_d   = onehot_in;
                        cnt_d   = dwell;
                    end else if (mode) begin
                        state_d = SCAN;
                        out_d   = {{(OUTS-1){1'b0}}, 1'b1};
                        cnt_d   = dwell;
                    end
                end

                // mode is deliberately not examined here: a hold always runs
                // to completion, and the mode switch takes effect via IDLE.
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (accept) begin
                        out_d = onehot_in;
                        cnt_d = dwell;
                    end else begin
                        state_d = IDLE;
                        out_d   = '0;
                    end
                end

                SCAN: begin
                    if (!mode) begin
                        state_d = IDLE;
                        out_d   = '0;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        out_d  = {out_q[OUTS-2:0], out_q[OUTS-1]};
                        cnt_d  = dwell;
                        wrap_d = out_q[OUTS-1];
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    out_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            valid_q <= |out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_onehot_sequencer.sv
// tb/tb_decoder_onehot_sequencer.sv - self-checking bench for decoder_onehot_sequencer

module tb_decoder_onehot_sequencer;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int OUTS = 16;

    logic            clk;
    logic            rst_n;
    logic            ena;
    logic            mode;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_idx;
    logic [DW-1:0]   dwell;
    logic [OUTS-1:0] out;
    logic            out_valid;
    logic            scan_wrap;

    decoder_onehot_sequencer #(.N(N), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_idx),
        .dwell     (dwell),
        .out       (out),
        .out_valid (out_valid),
        .scan_wrap (scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: what is being shown (nothing / a held index / a scan position),
    // which line, and how many more cycles it stays.
    int  m_kind;  // 0 none, 1 decode hold, 2 scan
    int  m_pos;
    int  m_rem;
    bit  m_wrap;

    logic [OUTS-1:0] obs_out;
    logic            obs_ready;
    logic            obs_wrap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUTS-1:0] model_out();
        logic [OUTS-1:0] v;
        v = '0;
        if (m_kind != 0) v[m_pos] = 1'b1;
        return v;
    endfunction

    function automatic bit model_ready();
        return ena && !mode && (m_kind == 0 || (m_kind == 1 && m_rem == 0));
    endfunction

    task automatic model_reset();
        m_kind = 0; m_pos = 0; m_rem = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        bit take;
        take   = model_ready() && in_valid;
        m_wrap = 0;
        if (!ena) begin
            m_kind = 0;
        end else if (m_kind == 0) begin
            if (take) begin
                m_kind = 1; m_pos = int'(in_idx); m_rem = int'(dwell);
            end else if (mode) begin
                m_kind = 2; m_pos = 0; m_rem = int'(dwell);
            end
        end else if (m_kind == 1) begin
            if (m_rem > 0) m_rem--;
            else if (take) begin
                m_pos = int'(in_idx); m_rem = int'(dwell);
            end else m_kind = 0;
        end else begin
            if (!mode) m_kind = 0;
            else if (m_rem == 0) begin
                m_wrap = (m_pos == OUTS - 1);
                m_pos  = (m_pos + 1) % OUTS;
                m_rem  = int'(dwell);
            end else m_rem--;
        end
    endtask

    // Called just after a falling edge with inputs already driven: compares
    // everything against the model, then advances one clock.
    task automatic step();
        #1;
        obs_out   = out;
        obs_ready = in_ready;
        obs_wrap  = scan_wrap;
        check("out",       32'(out),       32'(model_out()));
        check("out_valid", 32'(out_valid), 32'(m_kind != 0));
        check("scan_wrap", 32'(scan_wrap), 32'(m_wrap));
        check("in_ready",  32'(in_ready),  32'(model_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    int accepts;
    int wraps[$];

    initial begin
        rst_n = 1'b0; ena = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_idx = '0; dwell = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_out",   32'(out),       32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_wrap",  32'(scan_wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single decode, dwell=2, index 9.
        ena = 1'b1; mode = 1'b0; dwell = 8'd2; in_idx = 4'd9; in_valid = 1'b1;
        step();
        check("dec_ready_idle", 32'(obs_ready), 32'h1);
        in_valid = 1'b0;
        step();
        check("dec_out_c1",   32'(obs_out),   32'h0200);
        check("dec_ready_c1", 32'(obs_ready), 32'h0);
        step();
        check("dec_out_c2",   32'(obs_out),   32'h0200);
        check("dec_ready_c2", 32'(obs_ready), 32'h0);
        step();
        check("dec_out_c3",   32'(obs_out),   32'h0200);
        check("dec_ready_c3", 32'(obs_ready), 32'h1);
        step();
        check("dec_out_end",  32'(obs_out),   32'h0);

        // Back-to-back, dwell=0, one index per cycle.
        dwell = 8'd0; in_valid = 1'b1; accepts = 0;
        for (int k = 0; k < OUTS; k++) begin
            in_idx = 4'(k);
            step();
            if (obs_ready) accepts++;
            if (k > 0) check("b2b_out", 32'(obs_out), 32'(1) << (k - 1));
        end
        check("b2b_accepts", 32'(accepts), 32'd16);
        in_valid = 1'b0;
        step();
        check("b2b_last", 32'(obs_out), 32'h8000);
        step();
        check("b2b_idle", 32'(obs_out), 32'h0);

        // Scan, dwell=1: wrap every 32 cycles.
        mode = 1'b1; dwell = 8'd1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (obs_wrap) wraps.push_back(i);
        end
        check("scan_nwraps", 32'(wraps.size()), 32'd2);
        if (wraps.size() == 2) begin
            check("scan_wrap1", 32'(wraps[0]), 32'd33);
            check("scan_wrap2", 32'(wraps[1]), 32'd65);
        end

        // Asynchronous reset in the middle of the scan.
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_out",   32'(out),       32'h0);
        check("areset_valid", 32'(out_valid), 32'h0);
        check("areset_wrap",  32'(scan_wrap), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; mode = 1'b0;
        step();
        check("areset_ready", 32'(obs_ready), 32'h1);

        // ena dropped on the third cycle of a dwell=5 hold.
        dwell = 8'd5; in_idx = 4'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        ena = 1'b0;
        step();
        check("ena_ready_now", 32'(obs_ready), 32'h0);
        check("ena_out_still", 32'(obs_out),   32'h0008);
        step();
        check("ena_out_clear", 32'(obs_out),   32'h0);
        ena = 1'b1; in_idx = 4'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("ena_fresh", 32'(obs_out), 32'h0080);

        // Mode raised mid-hold: the hold finishes first.
        repeat (6) step();
        dwell = 8'd3; in_idx = 4'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0; mode = 1'b1;
        repeat (4) begin
            step();
            check("mode_hold", 32'(obs_out), 32'h0020);
        end
        repeat (10) step();
        mode = 1'b0;
        repeat (3) step();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            ena      = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            in_valid = $urandom_range(0, 1);
            in_idx   = 4'($urandom);
            dwell    = 8'($urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
